dmem_responder: RTL and testbench

//  Data-memory responder at the far end of the processor load/store request channel.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 33 +++
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// wait-counter width and an index-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // Index width for a storage of v words; never narrower than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: byte-enabled synchronous write, registered read.
// Contents are intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  rd_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (rd_i) rdata_q <= mem_q[idx_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYC wait states, then read/write and respond.
// Optional build macro DMEM_RANGE_CHECK_EN flags addresses >= DEPTH instead of wrapping them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int BE_W  = DATA_W / 8;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               rd_vld_q, rd_vld_d;

    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;

    logic               accept, commit, commit_ok;
    logic               acc_we, acc_err;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_wdata;
    logic [BE_W-1:0]    acc_be;
    logic [DATA_W-1:0]  arr_rdata;

    assign req_ready = (state_q == IDLE) & rst;
    assign accept    = req_valid & req_ready;

    // With WAIT_CYC = 0 the access happens on the accept edge, straight from the request.
    assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state_q == IDLE) ? req_be    : be_q;

`ifdef DMEM_RANGE_CHECK_EN
    assign acc_err = ({1'b0, acc_addr} >= (ADDR_W+1)'(DEPTH));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr;
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rd_vld_d = rd_vld_q;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYC == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYC - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d  = IDLE;
                    err_d    = 1'b0;
                    rd_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d    = acc_err;
            rd_vld_d = ~acc_we & ~acc_err;
        end
    end

    // A commit edge that coincides with reset must not touch storage.
    assign commit_ok = commit & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (commit_ok & acc_we & ~acc_err),
        .rd_i    (commit_ok & ~acc_we & ~acc_err),
        .idx_i   (acc_addr[IDX_W-1:0]),
        .wdata_i (acc_wdata),
        .be_i    (acc_be),
        .rdata_o (arr_rdata)
    );

    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rd_vld_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (ADDR_W=8, DEPTH=128, WAIT_CYC=2),
// using a word-array reference model; expectations follow DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 128;
    localparam int WAIT_CYC = 2;
    localparam int BE_W     = DATA_W / 8;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];

    dmem_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: word storage indexed by address modulo DEPTH; out-of-range when checking is built in.
    function automatic void model_exec(input bit we, input logic [ADDR_W-1:0] addr,
                                       input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be,
                                       output logic [DATA_W-1:0] exp_rdata, output bit exp_err);
        int idx;
        idx       = int'(addr) % DEPTH;
        exp_err   = RC && (int'(addr) >= DEPTH);
        exp_rdata = '0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < BE_W; b++)
                    if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_rdata = ref_mem[idx];
            end
        end
    endfunction

    // Present a request, wait for accept, then count cycles until rsp_valid (-1 on timeout).
    task automatic issue(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input logic [BE_W-1:0] be, output int lat);
        int g;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = ADDR_W'($urandom);
        req_wdata = $urandom; req_be = BE_W'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10;
        req_wdata = 32'h0; req_be = 4'hF; rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: ready=%b valid=%b err=%b rdata=%h, need 0 0 0 0",
                         req_ready, rsp_valid, rsp_err, rsp_rdata);
            end
        end
        rst = 1'b1; req_valid = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_ready: got %b need 1", req_ready);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_no_accept: ready=%b valid=%b need 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_write_read();
        int lat; logic [DATA_W-1:0] er; bit ee;
        model_exec(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, er, ee);
        issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat);
        n_cmp++;
        if (lat !== WAIT_CYC) begin n_bad++; $display("FAIL wr_latency: got %0d need %0d", lat, WAIT_CYC); end
        n_cmp++;
        if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL wr_resp: err=%b rdata=%h ready=%b need 0 0 0", rsp_err, rsp_rdata, req_ready);
        end
        release_rsp();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL wr_release: valid=%b ready=%b need 0 1", rsp_valid, req_ready);
        end
        model_exec(1'b0, 8'h10, 32'h0, 4'h0, er, ee);
        issue(1'b0, 8'h10, 32'h0, 4'h0, lat);
        n_cmp++;
        if (lat !== WAIT_CYC || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL rd_after_wr: lat=%0d rdata=%h err=%b need %0d deadbeef 0", lat, rsp_rdata, rsp_err, WAIT_CYC);
        end
        release_rsp();
        n_cmp++;
        if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL rd_clear: rdata=%h need 0", rsp_rdata); end
    endtask

    task automatic test_byte_enable();
        int lat; logic [DATA_W-1:0] er; bit ee;
        model_exec(1'b1, 8'h05, 32'h11223344, 4'hF, er, ee);
        issue(1'b1, 8'h05, 32'h11223344, 4'hF, lat); release_rsp();
        model_exec(1'b1, 8'h05, 32'hAABBCCDD, 4'h5, er, ee);
        issue(1'b1, 8'h05, 32'hAABBCCDD, 4'h5, lat); release_rsp();
        issue(1'b0, 8'h05, 32'h0, 4'h0, lat);
        n_cmp++;
        if (rsp_rdata !== 32'h11BB33DD) begin n_bad++; $display("FAIL byte_en: got %h need 11bb33dd", rsp_rdata); end
        release_rsp();
        model_exec(1'b1, 8'h05, 32'h55667788, 4'h0, er, ee);
        issue(1'b1, 8'h05, 32'h55667788, 4'h0, lat);
        n_cmp++;
        if (lat !== WAIT_CYC || rsp_err !== 1'b0) begin n_bad++; $display("FAIL be_zero_resp: lat=%0d err=%b need %0d 0", lat, rsp_err, WAIT_CYC); end
        release_rsp();
        issue(1'b0, 8'h05, 32'h0, 4'h0, lat);
        n_cmp++;
        if (rsp_rdata !== 32'h11BB33DD) begin n_bad++; $display("FAIL be_zero_unchanged: got %h need 11bb33dd", rsp_rdata); end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(1'b0, 8'h10, 32'h0, 4'h0, lat);
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL backpressure_c%0d: valid=%b rdata=%h ready=%b need 1 deadbeef 0", c, rsp_valid, rsp_rdata, req_ready);
            end
            req_valid = 1'($urandom); req_we = 1'b1; req_addr = 8'h10; req_wdata = $urandom; req_be = 4'hF;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        release_rsp();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_bad++; $display("FAIL backpressure_release: valid=%b ready=%b rdata=%h need 0 1 0", rsp_valid, req_ready, rsp_rdata);
        end
        issue(1'b0, 8'h10, 32'h0, 4'h0, lat);
        n_cmp++;
        if (rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL backpressure_ignored_req: got %h need deadbeef", rsp_rdata); end
        release_rsp();
    endtask

    task automatic test_reset_mid();
        int lat; logic [DATA_W-1:0] er; bit ee;
        model_exec(1'b1, 8'h07, 32'h12345678, 4'hF, er, ee);
        issue(1'b1, 8'h07, 32'h12345678, 4'hF, lat); release_rsp();
        req_we = 1'b1; req_addr = 8'h07; req_wdata = 32'hFFFFFFFF; req_be = 4'hF; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_in_reset: valid=%b ready=%b need 0 0", rsp_valid, req_ready);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_bad++; $display("FAIL abort_no_rsp_c%0d: valid=%b ready=%b need 0 1", c, rsp_valid, req_ready);
            end
        end
        issue(1'b0, 8'h07, 32'h0, 4'h0, lat);
        n_cmp++;
        if (rsp_rdata !== 32'h12345678) begin n_bad++; $display("FAIL abort_no_commit: got %h need 12345678", rsp_rdata); end
        release_rsp();
    endtask

    task automatic test_range();
        int lat; logic [DATA_W-1:0] er; bit ee;
        model_exec(1'b0, 8'h85, 32'h0, 4'h0, er, ee);
        issue(1'b0, 8'h85, 32'h0, 4'h0, lat);
        n_cmp++;
        if (lat !== WAIT_CYC || rsp_rdata !== er || rsp_err !== ee) begin
            n_bad++; $display("FAIL range_read: lat=%0d rdata=%h err=%b need %0d %h %b", lat, rsp_rdata, rsp_err, WAIT_CYC, er, ee);
        end
        release_rsp();
        n_cmp++;
        if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL range_err_clear: got %b need 0", rsp_err); end
        model_exec(1'b1, 8'hC5, 32'hCAFEF00D, 4'hF, er, ee);
        issue(1'b1, 8'hC5, 32'hCAFEF00D, 4'hF, lat);
        n_cmp++;
        if (rsp_err !== ee || rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL range_write: err=%b rdata=%h need %b 0", rsp_err, rsp_rdata, ee); end
        release_rsp();
        model_exec(1'b0, 8'h45, 32'h0, 4'h0, er, ee);
        issue(1'b0, 8'h45, 32'h0, 4'h0, lat);
        n_cmp++;
        if (rsp_rdata !== er) begin n_bad++; $display("FAIL range_write_effect: got %h need %h", rsp_rdata, er); end
        release_rsp();
    endtask

    task automatic test_back_to_back();
        int lat; logic [DATA_W-1:0] er, wd; bit ee, we; logic [ADDR_W-1:0] a; logic [BE_W-1:0] be;
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            model_exec(1'b1, ADDR_W'(i), wd, 4'hF, er, ee);
            issue(1'b1, ADDR_W'(i), wd, 4'hF, lat);
            release_rsp();
        end
        for (int t = 0; t < 80; t++) begin
            we = 1'($urandom); a = ADDR_W'($urandom); wd = $urandom; be = BE_W'($urandom);
            n_cmp++;
            if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_t%0d: got %b need 1", t, req_ready); end
            model_exec(we, a, wd, be, er, ee);
            issue(we, a, wd, be, lat);
            n_cmp++;
            if (lat !== WAIT_CYC || rsp_rdata !== er || rsp_err !== ee) begin
                n_bad++;
                $display("FAIL rand_t%0d we=%b addr=%h: lat=%0d rdata=%h err=%b need %0d %h %b",
                         t, we, a, lat, rsp_rdata, rsp_err, WAIT_CYC, er, ee);
            end
            release_rsp();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_backpressure();
        test_reset_mid();
        test_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
